// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM state encoding and small op-decode helpers.
package mdu_pkg;

  typedef enum logic [1:0] {
    MDU_MUL  = 2'b00,
    MDU_MULU = 2'b01,
    MDU_DIV  = 2'b10,
    MDU_DIVU = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } mdu_state_e;

  function automatic logic op_is_div(input logic [1:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == MDU_MUL) || (op == MDU_DIV);
  endfunction

endpackage

// File: rtl/mdu_signfix.sv
// Conditional two's-complement negation of a {hi, lo} pair, either lane by lane
// or, with joined=1, as one 2*WIDTH value (neg_hi then selects the negation).
module mdu_signfix #(
  parameter int WIDTH = 32
) (
  input  logic               joined,
  input  logic               neg_hi,
  input  logic               neg_lo,
  input  logic [WIDTH-1:0]   hi,
  input  logic [WIDTH-1:0]   lo,
  output logic [2*WIDTH-1:0] res
);

  logic [2*WIDTH-1:0] cat;
  logic [2*WIDTH-1:0] cat_neg;
  logic [WIDTH-1:0]   hi_fix;
  logic [WIDTH-1:0]   lo_fix;

  always_comb begin
    cat     = {hi, lo};
    cat_neg = -cat;
    hi_fix  = neg_hi ? -hi : hi;
    lo_fix  = neg_lo ? -lo : lo;
    if (joined) begin
      res = neg_hi ? cat_neg : cat;
    end else begin
      res = {hi_fix, lo_fix};
    end
  end

endmodule

// File: rtl/mdu_iter.sv
// Iterative radix-2 multiply/divide unit: one shift-add or restoring-subtract
// step per cycle, signed ops computed on magnitudes and corrected at the end.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   src_a,
  input  logic [WIDTH-1:0]   src_b,
  input  logic               annul,
  output logic               busy,
  output logic               ready,
  output logic [2*WIDTH-1:0] result,
  output logic               stallreq,
  output logic [1:0]         state_dbg
);

  // Handshake: start is accepted only in IDLE or DONE; ready is a one-cycle
  // pulse on the cycle result becomes valid; result holds until the next one.

  localparam int CW = $clog2(WIDTH) + 1;

  mdu_state_e         state;
  mdu_state_e         state_nxt;
  logic [CW-1:0]      cnt;
  logic [1:0]         op_q;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   b_q;
  logic               neg_hi_q;
  logic               neg_lo_q;

  logic               sgn;
  logic               is_div;
  logic               div_zero;
  logic               accept;
  logic               last_iter;
  logic               sign_diff;
  logic [2*WIDTH-1:0] mag;
  logic [2*WIDTH-1:0] res_fix;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     diff;

  assign sgn       = op_is_signed(op);
  assign is_div    = op_is_div(op);
  assign div_zero  = is_div && (src_b == '0);
  assign accept    = start && (state == ST_IDLE || state == ST_DONE);
  assign last_iter = (cnt == CW'(WIDTH - 1));
  assign sign_diff = sgn && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);

  // Operand magnitudes: mag = {|src_a|, |src_b|}
  mdu_signfix #(.WIDTH(WIDTH)) u_cond (
    .joined (1'b0),
    .neg_hi (sgn & src_a[WIDTH-1]),
    .neg_lo (sgn & src_b[WIDTH-1]),
    .hi     (src_a),
    .lo     (src_b),
    .res    (mag)
  );

  // Product is negated as a whole; quotient and remainder lane by lane.
  mdu_signfix #(.WIDTH(WIDTH)) u_fix (
    .joined (~op_is_div(op_q)),
    .neg_hi (neg_hi_q),
    .neg_lo (neg_lo_q),
    .hi     (acc[2*WIDTH-1:WIDTH]),
    .lo     (acc[WIDTH-1:0]),
    .res    (res_fix)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = div_zero ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        if (annul)          state_nxt = ST_IDLE;
        else if (last_iter) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (start) state_nxt = div_zero ? ST_DONE : ST_RUN;
        else       state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == ST_RUN);
    stallreq  = resetn && (busy || accept);
    state_dbg = state;
  end

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b_q} : '0);
    rem_sh  = acc[2*WIDTH-1:WIDTH-1];
    diff    = rem_sh - {1'b0, b_q};
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt      <= '0;
      op_q     <= '0;
      acc      <= '0;
      b_q      <= '0;
      neg_hi_q <= 1'b0;
      neg_lo_q <= 1'b0;
      result   <= '0;
      ready    <= 1'b0;
    end else begin
      ready <= (state == ST_DONE);
      if (state == ST_DONE) result <= res_fix;

      if (accept) begin
        cnt  <= '0;
        op_q <= op;
        if (div_zero) begin
          // Divide by zero bypasses RUN; acc already holds the final answer.
          acc      <= {src_a, {WIDTH{1'b1}}};
          b_q      <= '0;
          neg_hi_q <= 1'b0;
          neg_lo_q <= 1'b0;
        end else begin
          acc      <= {{WIDTH{1'b0}}, mag[2*WIDTH-1:WIDTH]};
          b_q      <= mag[WIDTH-1:0];
          neg_hi_q <= is_div ? (sgn & src_a[WIDTH-1]) : sign_diff;
          neg_lo_q <= sign_diff;
        end
      end else if (state == ST_RUN) begin
        cnt <= cnt + CW'(1);
        if (op_is_div(op_q)) begin
          if (!diff[WIDTH]) acc <= {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
          else              acc <= {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end else begin
          acc <= {mul_sum, acc[WIDTH-1:1]};
        end
      end
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Bench for mdu_iter (WIDTH=32): directed vector table, multi-cycle corner
// sequences and randomized operations against an arithmetic reference model.
module tb_mdu_iter;
  import mdu_pkg::*;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           resetn = 1'b0;
  logic           start = 1'b0;
  logic           annul = 1'b0;
  logic [1:0]     op = 2'b00;
  logic [W-1:0]   src_a = '0;
  logic [W-1:0]   src_b = '0;
  logic           busy;
  logic           ready;
  logic           stallreq;
  logic [2*W-1:0] result;
  logic [1:0]     state_dbg;

  int total = 0;
  int bad = 0;
  int ready_cnt = 0;
  logic [2*W-1:0] exp_q[$];

  typedef struct {
    logic [1:0]     o;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] e;
    int             lat;
  } vec_t;

  vec_t tbl[10];

  mdu_iter #(.WIDTH(W)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .op        (op),
    .src_a     (src_a),
    .src_b     (src_b),
    .annul     (annul),
    .busy      (busy),
    .ready     (ready),
    .result    (result),
    .stallreq  (stallreq),
    .state_dbg (state_dbg)
  );

  // clock / reset block
  always #5 clk = ~clk;

  always @(negedge clk) if (ready) ready_cnt++;

  initial begin
    #1000000;
    $display("FAIL watchdog: sim time limit reached, expected $finish earlier");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference model from the arithmetic definition of each op.
  function automatic logic [2*W-1:0] model(input logic [1:0] o, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    longint sa;
    longint sb;
    longint q;
    longint r;
    logic [2*W-1:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    res = '0;
    if (o == MDU_MUL) begin
      res = sa * sb;
    end else if (o == MDU_MULU) begin
      res = {32'b0, a} * {32'b0, b};
    end else if (b == 0) begin
      res = {a, 32'hFFFF_FFFF};
    end else if (o == MDU_DIV) begin
      q = sa / sb;
      r = sa % sb;
      res = {r[W-1:0], q[W-1:0]};
    end else begin
      res = {a % b, a / b};
    end
    return res;
  endfunction

  // driver: issue one op, wait for ready, check latency, flags and result
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] expv, input int lat, input string name);
    int n;
    bit got;
    bit flags_ok;
    logic [2*W-1:0] want;
    exp_q.push_back(expv);
    @(negedge clk);
    op = o; src_a = a; src_b = b; start = 1'b1;
    #1 check({name, " stall_at_start"}, stallreq, 1);
    @(posedge clk);
    #1 start = 1'b0;
    n = 0; got = 0; flags_ok = 1;
    while (!got && n < 200) begin
      @(posedge clk);
      n++;
      #1;
      if (ready) got = 1;
      else if (lat > 1 && n < lat - 1 && !(busy && stallreq)) flags_ok = 0;
      else if (lat > 1 && n == lat - 1 && (busy || stallreq)) flags_ok = 0;
    end
    check({name, " latency"}, n, lat);
    want = exp_q.pop_front();
    check({name, " result"}, result, want);
    if (lat > 1) check({name, " busy_stall"}, flags_ok, 1);
    @(posedge clk);
    #1 check({name, " ready_pulse"}, ready, 0);
    check({name, " result_hold"}, result, want);
  endtask

  initial begin
    int n;
    int rc0;
    int rdy_n[3];
    logic [2*W-1:0] rdy_r[3];
    int nr;
    logic [2*W-1:0] res_before;
    logic [1:0] o;
    logic [W-1:0] a;
    logic [W-1:0] b;

    tbl[0] = '{MDU_MUL,  32'hFFFF_FFFD, 32'd5,        64'hFFFF_FFFF_FFFF_FFF1, 33};
    tbl[1] = '{MDU_DIVU, 32'd100,       32'd7,        64'h0000_0002_0000_000E, 33};
    tbl[2] = '{MDU_DIV,  32'hFFFF_FFF9, 32'd2,        64'hFFFF_FFFF_FFFF_FFFD, 33};
    tbl[3] = '{MDU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 33};
    tbl[4] = '{MDU_DIVU, 32'h0000_1234, 32'd0,        64'h0000_1234_FFFF_FFFF, 1};
    tbl[5] = '{MDU_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 33};
    tbl[6] = '{MDU_DIV,  32'd7,         32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 33};
    tbl[7] = '{MDU_MUL,  32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 33};
    tbl[8] = '{MDU_DIV,  32'hFFFF_FF9C, 32'd0,        64'hFFFF_FF9C_FFFF_FFFF, 1};
    tbl[9] = '{MDU_MUL,  32'd7,         32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF9, 33};

    // reset state, with start held to confirm stallreq stays low
    resetn = 1'b0; start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst busy", busy, 0);
    check("rst ready", ready, 0);
    check("rst result", result, 0);
    check("rst state", state_dbg, ST_IDLE);
    check("rst stallreq", stallreq, 0);
    start = 1'b0; resetn = 1'b1;
    @(posedge clk);

    for (int i = 0; i < 10; i++) begin
      run_op(tbl[i].o, tbl[i].a, tbl[i].b, tbl[i].e, tbl[i].lat, $sformatf("vec%0d", i));
    end

    // annul at RUN cycle 10
    res_before = result;
    @(negedge clk);
    op = MDU_MULU; src_a = 32'd1234; src_b = 32'd5678; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    rc0 = ready_cnt;
    repeat (9) @(posedge clk);
    #1 annul = 1'b1;
    @(posedge clk);
    #1 annul = 1'b0;
    check("annul busy", busy, 0);
    check("annul state", state_dbg, ST_IDLE);
    check("annul stallreq", stallreq, 0);
    check("annul result", result, res_before);
    repeat (40) @(posedge clk);
    #1 check("annul no_ready", ready_cnt - rc0, 0);
    check("annul result_after", result, res_before);
    run_op(MDU_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 33, "post_annul");

    // reset at RUN cycle 5
    @(negedge clk);
    op = MDU_MUL; src_a = 32'hFFFF_FFFD; src_b = 32'd5; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 resetn = 1'b0; start = 1'b1;
    #1 check("midrst stallreq_low", stallreq, 0);
    @(posedge clk);
    #1;
    check("midrst state", state_dbg, ST_IDLE);
    check("midrst result", result, 0);
    check("midrst busy", busy, 0);
    check("midrst ready", ready, 0);
    check("midrst stallreq", stallreq, 0);
    start = 1'b0; resetn = 1'b1;
    @(posedge clk);

    // start held through DONE: three back-to-back ops
    @(negedge clk);
    op = MDU_MUL; src_a = 32'hFFFF_FFFD; src_b = 32'd5; start = 1'b1;
    @(posedge clk);
    n = 0; nr = 0;
    while (n < 110) begin
      @(posedge clk);
      n++;
      #1;
      if (ready) begin
        if (nr < 3) begin
          rdy_n[nr] = n;
          rdy_r[nr] = result;
        end
        nr++;
      end
      if (n == 32) check("b2b stall_in_done", stallreq, 1);
      if (n == 33) src_a = 32'd9;
      if (n == 66) start = 1'b0;
    end
    check("b2b ready_count", nr, 3);
    check("b2b t0", rdy_n[0], 33);
    check("b2b t1", rdy_n[1], 66);
    check("b2b t2", rdy_n[2], 99);
    check("b2b r0", rdy_r[0], model(MDU_MUL, 32'hFFFF_FFFD, 32'd5));
    check("b2b r1", rdy_r[1], model(MDU_MUL, 32'hFFFF_FFFD, 32'd5));
    check("b2b r2", rdy_r[2], model(MDU_MUL, 32'd9, 32'd5));

    // randomized ops against the model
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 20));
      if ($urandom_range(0, 7) == 0) b = 32'hFFFF_FFFF;
      run_op(o, a, b, model(o, a, b), (o[1] && b == 0) ? 1 : 33, $sformatf("rand%0d", i));
    end

    check("scoreboard drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
